// File: rtl/err_inject_sequencer.sv
// err_inject_sequencer: sole driver of err_en/err_ctrl into the error splitter tree (single/sweep injection).
// Define ERR_SEQ_RAND_EN to add mode 10 (LFSR-picked random sites) and the SELECT state.
module err_inject_sequencer #(
    parameter int INW       = 5,
    parameter int NUM_SITES = 25,
    parameter int CNTW      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      mode,
    input  logic [INW-1:0]  first_idx,
    input  logic [INW-1:0]  last_idx,
    input  logic [CNTW-1:0] delay,
    input  logic [CNTW-1:0] hold,
    output logic            busy,
    output logic            done,
    output logic            cfg_err,
    output logic            err_en,
    output logic [INW-1:0]  err_ctrl
);
    localparam logic [INW-1:0] LAST = INW'(NUM_SITES - 1);

    typedef enum logic [2:0] {
        IDLE, DELAY, INJECT, NEXT, DONE
`ifdef ERR_SEQ_RAND_EN
        , SELECT
`endif
    } state_t;

    state_t          state, nxt, ent;
    logic [INW-1:0]  cur, cur_n, last_q, last_n;
    logic [1:0]      mode_q, mode_n;
    logic [CNTW-1:0] cnt, cnt_n, dly_q, hld_q, dly_s, hld_s, hld_m1, ent_cnt;
    logic            bad, rej;

`ifdef ERR_SEQ_RAND_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif

    // in IDLE the live inputs are used so the first injection can start at T+1
    assign dly_s   = (state == IDLE) ? delay : dly_q;
    assign hld_s   = (state == IDLE) ? hold  : hld_q;
    assign hld_m1  = (hld_s == '0) ? '0 : hld_s - 1'b1;
    assign ent     = (dly_s == '0) ? INJECT : DELAY;
    assign ent_cnt = (dly_s == '0) ? hld_m1 : dly_s - 1'b1;

    assign bad = (mode == 2'b11)
`ifndef ERR_SEQ_RAND_EN
              || (mode == 2'b10)
`endif
              || (mode != 2'b10 && first_idx > LAST)
              || (mode == 2'b01 && (last_idx > LAST || last_idx < first_idx));

    always_comb begin
        nxt    = state;
        cnt_n  = cnt;
        cur_n  = cur;
        last_n = last_q;
        mode_n = mode_q;
        rej    = 1'b0;
        case (state)
            IDLE: if (start && !abort) begin
                if (bad) rej = 1'b1;
                else begin
                    mode_n = mode;
                    cur_n  = first_idx;
                    last_n = last_idx;
                    nxt    = ent;
                    cnt_n  = ent_cnt;
`ifdef ERR_SEQ_RAND_EN
                    if (mode == 2'b10) nxt = SELECT;
`endif
                end
            end
            DELAY: begin
                nxt   = (cnt == '0) ? INJECT : DELAY;
                cnt_n = (cnt == '0) ? hld_m1 : cnt - 1'b1;
            end
            INJECT: begin
                nxt   = (cnt == '0) ? NEXT : INJECT;
                cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
            end
            NEXT: begin
                nxt = DONE;
                if (mode_q == 2'b01 && cur != last_q) begin
                    cur_n = cur + 1'b1;
                    nxt   = ent;
                    cnt_n = ent_cnt;
                end
`ifdef ERR_SEQ_RAND_EN
                // last_q counts remaining random injections
                if (mode_q == 2'b10 && last_q != '0) begin
                    last_n = last_q - 1'b1;
                    nxt    = SELECT;
                end
`endif
            end
`ifdef ERR_SEQ_RAND_EN
            SELECT: if (lfsr[INW-1:0] <= LAST) begin
                cur_n = lfsr[INW-1:0];
                nxt   = ent;
                cnt_n = ent_cnt;
            end
`endif
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE && state != DONE) nxt = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur      <= '0;
            last_q   <= '0;
            mode_q   <= '0;
            dly_q    <= '0;
            hld_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            err_en   <= 1'b0;
            err_ctrl <= '0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_n;
            cur      <= cur_n;
            last_q   <= last_n;
            mode_q   <= mode_n;
            dly_q    <= dly_s;
            hld_q    <= hld_s;
            busy     <= nxt != IDLE;
            done     <= nxt == DONE;
            cfg_err  <= rej;
            err_en   <= nxt == INJECT;
            err_ctrl <= (nxt == INJECT) ? cur_n : '0;
        end
    end
endmodule
